// File: rtl/instruction_encoder.sv
// RV32I instruction packer that streams legal encoded words into instruction memory
// from a sequential address counter; out-of-range or misaligned immediates are counted and dropped.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err_sticky,
  output logic [7:0]            err_count
);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_wc;
  logic                  r_sticky;
  logic [7:0]            r_ecount;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_fit12;
  logic                  w_fitb;
  logic                  w_fitj;
  logic signed [31:0]    w_simm;
  logic [31:0]           w_word;

  assign w_simm   = imm;
  assign w_fit12  = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
  assign w_fitb   = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !imm[0];
  assign w_fitj   = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !imm[0];
  assign in_ready = (r_state == RUN) && !start;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (fmt)
      3'd0: begin
        w_word  = {funct7, rs2, rs1, funct3, rd, opcode};
        w_legal = 1'b1;
      end
      3'd1: begin
        w_word  = {imm[11:0], rs1, funct3, rd, opcode};
        w_legal = w_fit12;
      end
      3'd2: begin
        w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_legal = w_fit12;
      end
      3'd3: begin
        w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_legal = w_fitb;
      end
      3'd4: begin
        w_word  = {imm[31:12], rd, opcode};
        w_legal = (imm[11:0] == 12'd0);
      end
      3'd5: begin
        w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_legal = w_fitj;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // A write captured before a start still retires next cycle; start only clears counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_maddr  <= '0;
      r_wdata  <= '0;
      r_wc     <= '0;
      r_sticky <= 1'b0;
      r_ecount <= '0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_state  <= RUN;
        r_addr   <= BASE;
        r_wc     <= '0;
        r_sticky <= 1'b0;
        r_ecount <= '0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_maddr <= r_addr;
          r_wdata <= w_word;
          r_wc    <= r_wc + 1'b1;
          if (r_addr == LAST) r_state <= FULL;
          else                r_addr  <= r_addr + 1'b1;
        end else begin
          r_sticky <= 1'b1;
          if (r_ecount != 8'hFF) r_ecount <= r_ecount + 8'd1;
        end
      end
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_maddr;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state == RUN);
  assign full       = (r_state == FULL);
  assign word_count = r_wc;
  assign err_sticky = r_sticky;
  assign err_count  = r_ecount;
endmodule
